// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame data width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// Generic synchronous FIFO with a registered head (first-word-fall-through).
// Latency: a push into an empty FIFO is visible at head_dat/!empty on the next cycle.
// Backpressure: push while full is accepted only together with a pop; otherwise ignored.
module uart_rx_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    // Storage array; contents need no reset since occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers, occupancy and the registered head byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            head_dat <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
            // Head follows the next entry; when the FIFO drains it keeps the last byte.
            if (do_pop) begin
                if (count > CW'(1)) begin
                    head_dat <= mem[rd_ptr + AW'(1)];
                end else if (do_push) begin
                    head_dat <= push_dat;
                end
            end else if (do_push && empty) begin
                head_dat <= push_dat;
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a receive FIFO; UART_RX_PARITY_EN builds an 8E1 variant.
// Latency: byte at rx_data/rx_valid the cycle after the stop-bit sample (pin: 2 + 9.5*CLK_DIV + 1).
// Backpressure: rx_ready pops the head; a byte arriving to a full FIFO without a pop is dropped (overrun).
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 496,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          uart_rx,
    output logic [UART_DATA_BITS-1:0]     rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          overrun,
    output logic                          framing_error,
    input  logic                          clear_errors
`ifdef UART_RX_PARITY_EN
    ,
    output logic                          parity_error
`endif
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLK_DIV - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(UART_DATA_BITS - 1);

    logic                      sync1;
    logic                      rx_s;
    logic [1:0]                live;
    logic                      armed;
    rx_state_t                 state;
    logic [CW-1:0]             cnt;
    logic [IW-1:0]             idx;
    logic [UART_DATA_BITS-1:0] shreg;
    logic                      expire;
    logic                      stop_smp;
    logic                      push;
    logic                      fe_evt;
    logic                      ovr_evt;
    logic                      fifo_full;
    logic                      fifo_empty;
`ifdef UART_RX_PARITY_EN
    logic                      par_bad;
    logic                      pe_evt;
`endif

    // Two-flop synchroniser preset to idle-high; live marks when it carries real pin samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
            live  <= 2'b00;
        end else begin
            sync1 <= uart_rx;
            rx_s  <= sync1;
            live  <= {live[0], 1'b1};
        end
    end

    assign expire   = (cnt == '0);
    assign stop_smp = (state == STOP) && expire;
    assign fe_evt   = stop_smp && !rx_s;
`ifdef UART_RX_PARITY_EN
    assign push     = stop_smp && rx_s && !par_bad;
    assign pe_evt   = (state == PARITY) && expire && (rx_s ^ (^shreg));
`else
    assign push     = stop_smp && rx_s;
`endif
    assign ovr_evt  = push && fifo_full && !rx_ready;

    // Frame FSM; armed blocks a line held low through reset from starting a frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            armed <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else begin
            armed <= armed | (live[1] & rx_s);
            case (state)
                IDLE: begin
                    if (armed && !rx_s) begin
                        state <= START;
                        cnt   <= HALF_LOAD;
                    end
                end
                START: begin
                    if (expire) begin
                        if (!rx_s) begin
                            state <= DATA;
                            cnt   <= FULL_LOAD;
                            idx   <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DATA: begin
                    if (expire) begin
                        shreg <= {rx_s, shreg[UART_DATA_BITS-1:1]};
                        cnt   <= FULL_LOAD;
                        if (idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (expire) begin
                        par_bad <= rx_s ^ (^shreg);
                        cnt     <= FULL_LOAD;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
`endif
                STOP: begin
                    if (expire) begin
                        state <= rx_s ? IDLE : BREAK;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky error flags; a set event in the clear cycle keeps the flag high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun       <= 1'b0;
            framing_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error  <= 1'b0;
`endif
        end else begin
            overrun       <= ovr_evt | (overrun & ~clear_errors);
            framing_error <= fe_evt | (framing_error & ~clear_errors);
`ifdef UART_RX_PARITY_EN
            parity_error  <= pe_evt | (parity_error & ~clear_errors);
`endif
        end
    end

    uart_rx_sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat (shreg),
        .pop      (rx_ready),
        .head_dat (rx_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (rx_count)
    );

    assign rx_valid = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo at CLK_DIV=16, FIFO_DEPTH=4.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx_fifo;

    localparam int D     = 16;
    localparam int DEPTH = 4;
    localparam int OP_SEND  = 0;
    localparam int OP_POP   = 1;
    localparam int OP_CLEAR = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       uart_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [2:0] rx_count;
    logic       overrun;
    logic       framing_error;
    logic       clear_errors;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int         op;
        logic [7:0] dat;
        logic       stop;
        logic [7:0] head;
        logic       vld;
        int         cnt;
        logic       fe;
        logic       ov;
    } vec_t;

    vec_t vecs [12];

    logic [7:0] mq [$];
    logic       m_fe;
    logic       m_ov;
    logic [7:0] m_last;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLK_DIV    (D),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .uart_rx       (uart_rx),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_count      (rx_count),
        .overrun       (overrun),
        .framing_error (framing_error),
        .clear_errors  (clear_errors)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] head, input logic vld,
                             input int cnt, input logic fe, input logic ov);
        check($sformatf("%s.rx_data", tag), 32'(rx_data), 32'(head));
        check($sformatf("%s.rx_valid", tag), 32'(rx_valid), 32'(vld));
        check($sformatf("%s.rx_count", tag), 32'(rx_count), 32'(cnt));
        check($sformatf("%s.framing_error", tag), 32'(framing_error), 32'(fe));
        check($sformatf("%s.overrun", tag), 32'(overrun), 32'(ov));
    endtask

    // All tasks start and end #1 after a rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop, input int cycles);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int c = 0; c < cycles; c++) begin
            uart_rx = f[c / D];
            tick(1);
        end
        uart_rx = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_frame(d, stop, 10 * D);
        tick(2 * D);
    endtask

    task automatic pop_pulse();
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    task automatic clear_pulse();
        clear_errors = 1'b1;
        tick(1);
        clear_errors = 1'b0;
    endtask

    // Reference model: a byte queue plus two flags, driven by whole frames.
    task automatic model_send(input logic [7:0] d, input logic stop);
        if (!stop) m_fe = 1'b1;
        else if (mq.size() < DEPTH) mq.push_back(d);
        else m_ov = 1'b1;
    endtask

    task automatic model_check(input string tag);
        if (mq.size() > 0) m_last = mq[0];
        check_all(tag, m_last, mq.size() > 0, mq.size(), m_fe, m_ov);
    endtask

    initial begin
        logic [7:0] d;
        logic       s;
        int         np;

        reset        = 1'b1;
        uart_rx      = 1'b1;
        rx_ready     = 1'b0;
        clear_errors = 1'b0;
        tick(3);
        check_all("reset", 8'h00, 1'b0, 0, 1'b0, 1'b0);
        reset = 1'b0;
        tick(4);

        // Short low pulse is rejected at the start-bit midpoint.
        uart_rx = 1'b0;
        tick(4);
        uart_rx = 1'b1;
        tick(3 * D);
        check_all("glitch", 8'h00, 1'b0, 0, 1'b0, 1'b0);

        vecs[0]  = '{OP_SEND,  8'h55, 1'b1, 8'h55, 1'b1, 1, 1'b0, 1'b0};
        vecs[1]  = '{OP_SEND,  8'hA3, 1'b1, 8'h55, 1'b1, 2, 1'b0, 1'b0};
        vecs[2]  = '{OP_POP,   8'h00, 1'b1, 8'hA3, 1'b1, 1, 1'b0, 1'b0};
        vecs[3]  = '{OP_POP,   8'h00, 1'b1, 8'hA3, 1'b0, 0, 1'b0, 1'b0};
        vecs[4]  = '{OP_SEND,  8'h7E, 1'b0, 8'hA3, 1'b0, 0, 1'b1, 1'b0};
        vecs[5]  = '{OP_CLEAR, 8'h00, 1'b1, 8'hA3, 1'b0, 0, 1'b0, 1'b0};
        vecs[6]  = '{OP_SEND,  8'h01, 1'b1, 8'h01, 1'b1, 1, 1'b0, 1'b0};
        vecs[7]  = '{OP_SEND,  8'h02, 1'b1, 8'h01, 1'b1, 2, 1'b0, 1'b0};
        vecs[8]  = '{OP_SEND,  8'h03, 1'b1, 8'h01, 1'b1, 3, 1'b0, 1'b0};
        vecs[9]  = '{OP_SEND,  8'h04, 1'b1, 8'h01, 1'b1, 4, 1'b0, 1'b0};
        vecs[10] = '{OP_SEND,  8'h05, 1'b1, 8'h01, 1'b1, 4, 1'b0, 1'b1};
        vecs[11] = '{OP_CLEAR, 8'h00, 1'b1, 8'h01, 1'b1, 4, 1'b0, 1'b0};

        for (int i = 0; i < 12; i++) begin
            case (vecs[i].op)
                OP_SEND: send_frame(vecs[i].dat, vecs[i].stop);
                OP_POP:  pop_pulse();
                default: clear_pulse();
            endcase
            check_all($sformatf("vec%0d", i), vecs[i].head, vecs[i].vld,
                      vecs[i].cnt, vecs[i].fe, vecs[i].ov);
        end

        // Full FIFO, pop coincides with the push cycle (stop sample is 154 cycles after start edge).
        fork
            send_frame(8'hAA, 1'b1);
            begin
                tick(153);
                @(posedge clk);
                #1;
                rx_ready = 1'b1;
                tick(1);
                rx_ready = 1'b0;
            end
        join
        check_all("full_pushpop", 8'h02, 1'b1, 4, 1'b0, 1'b0);
        pop_pulse();
        check("drain0", 32'(rx_data), 32'h03);
        pop_pulse();
        check("drain1", 32'(rx_data), 32'h04);
        pop_pulse();
        check("drain2", 32'(rx_data), 32'hAA);
        pop_pulse();
        check_all("drained", 8'hAA, 1'b0, 0, 1'b0, 1'b0);

        // Held-low break: one framing error only, even after clearing while still low.
        drive_frame(8'h7E, 1'b0, 10 * D);
        uart_rx = 1'b0;
        tick(2 * D);
        check("break.fe_set", 32'(framing_error), 32'h1);
        clear_pulse();
        tick(3 * D);
        check("break.fe_low", 32'(framing_error), 32'h0);
        uart_rx = 1'b1;
        tick(2 * D);
        check_all("break.end", 8'hAA, 1'b0, 0, 1'b0, 1'b0);
        send_frame(8'h99, 1'b1);
        check_all("after_break", 8'h99, 1'b1, 1, 1'b0, 1'b0);

        // Line low across reset release must not start a frame.
        uart_rx = 1'b0;
        reset   = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(10 * D);
        uart_rx = 1'b1;
        tick(2 * D);
        check_all("low_release", 8'h00, 1'b0, 0, 1'b0, 1'b0);

        // Reset in the middle of bit 3 of 0xC4, released with the line high.
        drive_frame(8'hC4, 1'b1, 4 * D + D / 2);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(4);
        check_all("midreset", 8'h00, 1'b0, 0, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b1);
        check_all("post_reset", 8'h3C, 1'b1, 1, 1'b0, 1'b0);
        pop_pulse();

        // Randomised frames, pops and clears against the queue model.
        m_fe   = 1'b0;
        m_ov   = 1'b0;
        m_last = 8'h3C;
        for (int i = 0; i < 30; i++) begin
            d = 8'($urandom_range(0, 255));
            s = ($urandom_range(0, 5) != 0);
            send_frame(d, s);
            model_send(d, s);
            model_check($sformatf("rnd%0d.send", i));
            np = $urandom_range(0, 2);
            for (int p = 0; p < np; p++) begin
                pop_pulse();
                if (mq.size() > 0) void'(mq.pop_front());
                model_check($sformatf("rnd%0d.pop%0d", i, p));
            end
            if ($urandom_range(0, 6) == 0) begin
                clear_pulse();
                m_fe = 1'b0;
                m_ov = 1'b0;
                model_check($sformatf("rnd%0d.clr", i));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
